// File: rtl/message_scroller.sv
// Scrolling character window over a writable message store.
// Advances are timer-driven (auto) or step-driven (manual); chars is registered.
module message_scroller #(
  parameter int unsigned CHAR_W  = 4,
  parameter int unsigned MSG_LEN = 16,
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned PERIOD  = 4194304
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         mode,
  input  logic                         dir,
  input  logic                         step,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_LEN)-1:0]   wr_addr,
  input  logic [CHAR_W-1:0]            wr_data,
  output logic [DIGITS*CHAR_W-1:0]     chars,
  output logic [$clog2(MSG_LEN)-1:0]   pos,
  output logic                         wrap
);

  localparam int unsigned AW = $clog2(MSG_LEN);
  localparam int unsigned TW = $clog2(PERIOD);

  localparam logic [AW-1:0] LastPos  = AW'(MSG_LEN - 1);
  localparam logic [TW-1:0] LastTime = TW'(PERIOD - 1);

  logic [CHAR_W-1:0]        msg_q [MSG_LEN];
  logic [AW-1:0]            pos_q, pos_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic                     wrap_q, wrap_d;
  logic [DIGITS*CHAR_W-1:0] chars_q, chars_d;

  logic auto_run;
  logic tick;
  logic advance;
  logic wr_ok;

  assign auto_run = enable && !mode;
  assign tick     = auto_run && (timer_q == LastTime);
  assign advance  = enable && (mode ? step : tick);
  // Out-of-range addresses only exist when MSG_LEN is not a power of two.
  assign wr_ok    = wr_en && (32'(wr_addr) < 32'(MSG_LEN));

  always_comb begin
    timer_d = '0;
    if (auto_run && !tick) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_comb begin
    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (advance) begin
      if (!dir) begin
        if (pos_q == LastPos) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q + AW'(1);
        end
      end else begin
        if (pos_q == '0) begin
          pos_d  = LastPos;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q - AW'(1);
        end
      end
    end
  end

  // Window built from the pre-edge pos and message, giving one cycle of latency.
  always_comb begin
    logic [AW:0] idx;
    chars_d = '0;
    idx     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      idx = {1'b0, pos_q} + (AW+1)'(k);
      if (idx >= (AW+1)'(MSG_LEN)) begin
        idx = idx - (AW+1)'(MSG_LEN);
      end
      chars_d[(DIGITS-1-k)*CHAR_W +: CHAR_W] = msg_q[idx[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_q[i] <= CHAR_W'(i);
      end
    end else if (wr_ok) begin
      msg_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q   <= '0;
      timer_q <= '0;
      wrap_q  <= 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
        chars_q[(DIGITS-1-k)*CHAR_W +: CHAR_W] <= CHAR_W'(k);
      end
    end else begin
      pos_q   <= pos_d;
      timer_q <= timer_d;
      wrap_q  <= wrap_d;
      chars_q <= chars_d;
    end
  end

  assign chars = chars_q;
  assign pos   = pos_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_message_scroller.sv
// Directed bench for message_scroller with CHAR_W=4, MSG_LEN=16, DIGITS=4, PERIOD=4.
module tb_message_scroller;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        mode;
  logic        dir;
  logic        step;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [15:0] chars;
  logic [3:0]  pos;
  logic        wrap;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  message_scroller #(
    .CHAR_W (4),
    .MSG_LEN(16),
    .DIGITS (4),
    .PERIOD (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .dir    (dir),
    .step   (step),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .chars  (chars),
    .pos    (pos),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, ending on a falling edge.
  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset pulse released on a falling edge with the given control setup.
  task automatic do_reset(input logic en, input logic md, input logic dr);
    reset = 1'b0;
    enable = en;
    mode = md;
    dir = dr;
    step = 1'b0;
    wr_en = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    mode    = 1'b0;
    dir     = 1'b0;
    step    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    #1;

    // Auto forward from reset
    reset = 1'b0;
    #1;
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_chars", 32'(chars), 32'h0123);
    check("rst_wrap", 32'(wrap), 32'd0);
    do_reset(1'b1, 1'b0, 1'b0);
    edges(3);
    check("auto_hold3", 32'(pos), 32'd0);
    edges(1);
    check("auto_pos1", 32'(pos), 32'd1);
    check("auto_chars_lag", 32'(chars), 32'h0123);
    edges(1);
    check("auto_chars1", 32'(chars), 32'h1234);
    edges(3);
    check("auto_pos2", 32'(pos), 32'd2);
    edges(4);
    check("auto_pos3", 32'(pos), 32'd3);
    check("auto_chars2", 32'(chars), 32'h2345);

    // Run through to wrap-around
    edges(48);
    check("run_pos15", 32'(pos), 32'd15);
    check("run_chars14", 32'(chars), 32'hEF01);
    edges(1);
    check("run_chars15", 32'(chars), 32'hF012);
    edges(2);
    check("run_nowrap", 32'(wrap), 32'd0);
    edges(1);
    check("run_wrap_pos", 32'(pos), 32'd0);
    check("run_wrap", 32'(wrap), 32'd1);
    edges(1);
    check("run_wrap_low", 32'(wrap), 32'd0);
    check("run_chars0", 32'(chars), 32'h0123);

    // Freeze mid-count, then a full period after re-enable
    enable = 1'b0;
    edges(10);
    check("frz_pos", 32'(pos), 32'd0);
    enable = 1'b1;
    edges(3);
    check("reen_hold", 32'(pos), 32'd0);
    edges(1);
    check("reen_adv", 32'(pos), 32'd1);

    // Manual backward single step from reset
    do_reset(1'b1, 1'b1, 1'b1);
    step = 1'b1;
    edges(1);
    step = 1'b0;
    check("man_back_pos", 32'(pos), 32'd15);
    check("man_back_wrap", 32'(wrap), 32'd1);
    edges(1);
    check("man_back_chars", 32'(chars), 32'hF012);
    check("man_back_wrap_low", 32'(wrap), 32'd0);
    edges(6);
    check("man_no_tick", 32'(pos), 32'd15);
    dir = 1'b0;
    edges(1);
    check("dir_no_move", 32'(pos), 32'd15);
    step = 1'b1;
    edges(1);
    step = 1'b0;
    check("man_fwd_wrap_pos", 32'(pos), 32'd0);
    check("man_fwd_wrap", 32'(wrap), 32'd1);

    // Write together with a manual forward step
    do_reset(1'b1, 1'b1, 1'b0);
    wr_en = 1'b1;
    wr_addr = 4'd2;
    wr_data = 4'hA;
    step = 1'b1;
    edges(1);
    wr_en = 1'b0;
    step = 1'b0;
    check("wrstep_pos", 32'(pos), 32'd1);
    check("wrstep_chars_lag", 32'(chars), 32'h0123);
    edges(1);
    check("wrstep_chars", 32'(chars), 32'h1A34);
    step = 1'b1;
    edges(3);
    step = 1'b0;
    check("held_step_pos", 32'(pos), 32'd4);
    edges(1);
    check("held_step_chars", 32'(chars), 32'h4567);

    // Step ignored in auto; auto restarts a full period after manual
    mode = 1'b0;
    step = 1'b1;
    edges(2);
    check("auto_ign_step", 32'(pos), 32'd4);
    step = 1'b0;
    edges(1);
    check("auto_restart_hold", 32'(pos), 32'd4);
    edges(1);
    check("auto_restart_adv", 32'(pos), 32'd5);

    // Asynchronous reset mid-scroll discards writes
    do_reset(1'b1, 1'b1, 1'b0);
    wr_en = 1'b1;
    wr_addr = 4'd8;
    wr_data = 4'hC;
    edges(1);
    wr_en = 1'b0;
    check("wr_only_pos", 32'(pos), 32'd0);
    step = 1'b1;
    edges(7);
    step = 1'b0;
    check("pre_rst_pos", 32'(pos), 32'd7);
    edges(1);
    check("pre_rst_chars", 32'(chars), 32'h7C9A);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_pos", 32'(pos), 32'd0);
    check("async_chars", 32'(chars), 32'h0123);
    check("async_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step = 1'b1;
    edges(7);
    step = 1'b0;
    check("post_rst_pos", 32'(pos), 32'd7);
    edges(1);
    check("post_rst_chars", 32'(chars), 32'h789A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
